ifu_fetch: RTL and testbench

- Instruction fetch unit directly upstream of the control decoder in the NPC core.
- Owns the architectural PC and fetches one instruction at a time from instruction memory over a valid/ready request and response interface.
- Holds the fetched word stable on `inst` until the datapath signals commit.
- Computes the next PC from the decoder's PCSrc selection and the ALU result.

---
 rtl/ifu_fetch.sv | 118 +++++++++++
 tb/tb_ifu_fetch.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_fetch.sv
// Instruction fetch: owns the PC, issues one imem request at a time, holds inst until commit.
// Latency: request accept -> inst_valid in 2 cycles minimum; stalls in REQ while imem_req_ready=0.
module ifu_fetch #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter int unsigned TIMEOUT  = 255,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_req_valid,
    input  logic             imem_req_ready,
    output logic [31:0]      imem_req_addr,
    input  logic             imem_resp_valid,
    input  logic [31:0]      imem_resp_data,
    input  logic             imem_resp_err,
    output logic [31:0]      inst,
    output logic [31:0]      inst_pc,
    output logic             inst_valid,
    input  logic             commit,
    input  logic             pc_src,
    input  logic [31:0]      alu_result,
    output logic             fetch_fault,
    output logic [CNT_W-1:0] retired_cnt
);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD,
        FAULT
    } state_t;

    localparam int             TO_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
    localparam bit             TO_EN   = (TIMEOUT != 0);
    localparam logic [31:0]    NOP     = 32'h0000_0013;

    state_t            state_q, state_d;
    logic [31:0]       pc_q, pc_d;
    logic [31:0]       inst_q, inst_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [TO_W-1:0]   to_q, to_d;
    logic [31:0]       npc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            inst_q  <= NOP;
            cnt_q   <= '0;
            to_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            cnt_q   <= cnt_d;
            to_q    <= to_d;
        end
    end

    // Jump targets always drop bit 0; pc+4 keeps pc's bit 0, which is never set.
    assign npc = (pc_src ? alu_result : (pc_q + 32'd4)) & 32'hFFFF_FFFE;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        cnt_d   = cnt_q;
        to_d    = to_q;
        case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                if (imem_req_ready) begin
                    state_d = WAIT;
                    to_d    = '0;
                end
            end
            WAIT: begin
                if (imem_resp_valid) begin
                    if (imem_resp_err) begin
                        state_d = FAULT;
                    end else begin
                        inst_d  = imem_resp_data;
                        state_d = HOLD;
                    end
                end else if (TO_EN && (to_q == TO_LAST)) begin
                    state_d = FAULT;
                end else begin
                    to_d = to_q + 1'b1;
                end
            end
            HOLD: begin
                if (commit) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    // A misaligned target faults with pc still naming the offending instruction.
                    if (npc[1]) begin
                        state_d = FAULT;
                    end else begin
                        pc_d    = npc;
                        state_d = REQ;
                    end
                end
            end
            FAULT:   state_d = FAULT;
            default: state_d = FAULT;
        endcase
    end

    assign imem_req_valid = (state_q == REQ);
    assign imem_req_addr  = pc_q;
    assign inst           = inst_q;
    assign inst_pc        = pc_q;
    assign inst_valid     = (state_q == HOLD);
    assign fetch_fault    = (state_q == FAULT);
    assign retired_cnt    = cnt_q;

endmodule

// File: tb/tb_ifu_fetch.sv
module tb_ifu_fetch;

    localparam logic [31:0] RPC = 32'h8000_0000;
    localparam int          CW  = 8;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid, req_ready;
    logic [31:0]   req_addr;
    logic          resp_valid, resp_err;
    logic [31:0]   resp_data;
    logic [31:0]   inst, inst_pc;
    logic          inst_valid, fetch_fault;
    logic          commit, pc_src;
    logic [31:0]   alu;
    logic [CW-1:0] retired_cnt;

    ifu_fetch #(.RESET_PC(RPC), .TIMEOUT(4), .CNT_W(CW)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (req_valid),
        .imem_req_ready (req_ready),
        .imem_req_addr  (req_addr),
        .imem_resp_valid(resp_valid),
        .imem_resp_data (resp_data),
        .imem_resp_err  (resp_err),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_valid     (inst_valid),
        .commit         (commit),
        .pc_src         (pc_src),
        .alu_result     (alu),
        .fetch_fault    (fetch_fault),
        .retired_cnt    (retired_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] cnt;
    } exp_t;

    exp_t        sb[$];
    int          n_chk = 0;
    int          n_fail = 0;
    logic [31:0] m_pc = RPC;
    int          m_cnt = 0;

    // Memory mode 0: copies man_* values; mode 1: randomized responder.
    int          mem_mode = 0;
    logic        man_ready = 1'b0, man_rv = 1'b0, man_err = 1'b0;
    logic [31:0] man_data = '0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == RPC) return 32'h0050_0093;
        return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] pc, input int cnt);
        exp_t e;
        e.pc   = pc;
        e.inst = mem_word(pc);
        e.cnt  = 32'(cnt % (1 << CW));
        sb.push_back(e);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_req_valid"}, 32'(req_valid), 0);
        chk({tag, "_inst_valid"}, 32'(inst_valid), 0);
        chk({tag, "_fault"}, 32'(fetch_fault), 0);
        chk({tag, "_cnt"}, 32'(retired_cnt), 0);
        chk({tag, "_inst"}, inst, NOP);
        chk({tag, "_pc"}, inst_pc, RPC);
    endtask

    // Called at posedge+1; asserts and releases rst between clock edges.
    task automatic pulse_reset(input string tag);
        #1 rst = 1'b1;
        #1 chk_reset_vals(tag);
        #1 rst = 1'b0;
    endtask

    // Called at posedge+1 with the DUT in REQ.
    task automatic fetch_manual(input logic [31:0] addr, input logic [31:0] data);
        chk("fetch_req_valid", 32'(req_valid), 1);
        chk("fetch_req_addr", req_addr, addr);
        man_ready = 1'b1;
        @(posedge clk); #1;
        man_ready = 1'b0;
        commit    = 1'b0;
        chk("fetch_wait_no_req", 32'(req_valid), 0);
        chk("fetch_wait_no_valid", 32'(inst_valid), 0);
        man_rv   = 1'b1;
        man_data = data;
        @(posedge clk); #1;
        man_rv = 1'b0;
        chk("fetch_lat2_valid", 32'(inst_valid), 1);
        chk("fetch_inst", inst, data);
        chk("fetch_inst_pc", inst_pc, addr);
    endtask

    // Instruction memory model.
    initial begin
        bit          pend = 0;
        int          dly = 0;
        logic [31:0] paddr = '0;
        req_ready = 1'b0; resp_valid = 1'b0; resp_err = 1'b0; resp_data = '0;
        forever begin
            @(negedge clk);
            if (mem_mode == 0 || rst) begin
                pend       = 0;
                req_ready  = man_ready;
                resp_valid = man_rv;
                resp_err   = man_err;
                resp_data  = man_data;
            end else begin
                resp_valid = 1'b0;
                resp_err   = 1'b0;
                resp_data  = $urandom;
                if (pend) begin
                    if (dly == 0) begin
                        resp_valid = 1'b1;
                        resp_data  = mem_word(paddr);
                        pend       = 0;
                    end else begin
                        dly--;
                    end
                end else if (inst_valid && $urandom_range(0, 2) == 0) begin
                    resp_valid = 1'b1;
                end
                if (req_valid) chk("req_addr", req_addr, m_pc);
                req_ready = ($urandom_range(0, 2) != 0);
                if (!pend && req_valid && req_ready) begin
                    pend  = 1;
                    paddr = req_addr;
                    dly   = $urandom_range(0, 3);
                end
            end
        end
    end

    // Scoreboard monitor: one expected entry per HOLD, and HOLD must be stable.
    initial begin
        logic prev = 1'b0;
        exp_t cur = '0;
        forever begin
            @(posedge clk); #1;
            if (inst_valid && !prev) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL sb_unexpected_hold: got hold at pc %h expected none", inst_pc);
                end else begin
                    cur = sb.pop_front();
                    chk("sb_inst", inst, cur.inst);
                    chk("sb_inst_pc", inst_pc, cur.pc);
                    chk("sb_retired_cnt", 32'(retired_cnt), cur.cnt);
                end
            end else if (inst_valid && prev) begin
                chk("hold_stable_inst", inst, cur.inst);
                chk("hold_stable_pc", inst_pc, cur.pc);
            end
            prev = inst_valid;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, required finish before 1ms");
        $fatal(1);
    end

    initial begin
        int          nret = 0;
        int          cyc = 0;
        logic [31:0] tmp, fpc;
        rst = 1'b1; commit = 1'b0; pc_src = 1'b0; alu = '0;

        // Reset and first fetch
        repeat (2) @(posedge clk);
        #1 chk_reset_vals("rst");
        #3 rst = 1'b0;
        @(posedge clk); #1;
        push_exp(RPC, 0);
        fetch_manual(RPC, 32'h0050_0093);

        man_rv = 1'b1; man_data = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        man_rv = 1'b0;
        chk("spurious_resp_hold", inst, 32'h0050_0093);

        // Sequential step, ready held low, commit held through REQ/WAIT
        commit = 1'b1; pc_src = 1'b0;
        m_pc = RPC + 32'd4; m_cnt = 1;
        push_exp(m_pc, m_cnt);
        @(posedge clk); #1;
        chk("seq_cnt", 32'(retired_cnt), 1);
        for (int i = 0; i < 3; i++) begin
            chk("stall_req_valid", 32'(req_valid), 1);
            chk("stall_req_addr", req_addr, 32'h8000_0004);
            chk("stall_cnt", 32'(retired_cnt), 1);
            @(posedge clk); #1;
        end
        fetch_manual(32'h8000_0004, mem_word(32'h8000_0004));

        // Randomized program flow
        mem_mode = 1;
        while (cyc < 20000) begin
            @(negedge clk);
            cyc++;
            if (inst_valid) begin
                if (nret >= 300) begin
                    commit = 1'b0;
                    break;
                end
                if ($urandom_range(0, 2) == 0) begin
                    commit = 1'b1;
                    pc_src = 1'($urandom_range(0, 1));
                    tmp    = $urandom;
                    if (tmp[31:29] == 3'd0) alu = 32'hFFFF_FFFD;
                    else alu = {m_pc[31:12], tmp[11:2], 1'b0, tmp[0]};
                    if (pc_src) m_pc = alu - (alu % 2);
                    else m_pc = m_pc + 32'd4;
                    m_cnt++;
                    nret++;
                    push_exp(m_pc, m_cnt);
                end else begin
                    commit = 1'b0;
                end
            end else begin
                commit = 1'($urandom_range(0, 1));
                pc_src = 1'($urandom_range(0, 1));
                alu    = $urandom;
            end
        end
        chk("random_phase_done", 32'(cyc < 20000), 1);

        // Misaligned jump
        fpc    = m_pc;
        commit = 1'b1; pc_src = 1'b1; alu = {m_pc[31:12], 12'h102};
        @(posedge clk); #1;
        mem_mode = 0;
        chk("misalign_fault", 32'(fetch_fault), 1);
        chk("misalign_no_valid", 32'(inst_valid), 0);
        chk("misalign_pc", inst_pc, fpc);
        chk("misalign_cnt", 32'(retired_cnt), 32'((m_cnt + 1) % (1 << CW)));
        man_rv = 1'b1; man_data = 32'h1111_2222; man_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("fault_sticky", 32'(fetch_fault), 1);
            chk("fault_no_req", 32'(req_valid), 0);
            chk("fault_cnt_frozen", 32'(retired_cnt), 32'((m_cnt + 1) % (1 << CW)));
        end
        man_rv = 1'b0; man_ready = 1'b0; commit = 1'b0;

        // Response error
        pulse_reset("rst_err");
        @(posedge clk); #1;
        man_ready = 1'b1;
        @(posedge clk); #1;
        man_ready = 1'b0; man_rv = 1'b1; man_err = 1'b1; man_data = 32'h1234_5678;
        @(posedge clk); #1;
        man_rv = 1'b0; man_err = 1'b0;
        chk("err_fault", 32'(fetch_fault), 1);
        chk("err_inst_kept", inst, NOP);
        chk("err_no_valid", 32'(inst_valid), 0);

        // Timeout after 4 WAIT cycles
        pulse_reset("rst_to");
        @(posedge clk); #1;
        man_ready = 1'b1;
        @(posedge clk); #1;
        man_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("timeout_early", 32'(fetch_fault), 0);
        end
        @(posedge clk); #1;
        chk("timeout_fault", 32'(fetch_fault), 1);
        chk("timeout_no_req", 32'(req_valid), 0);

        // Async reset mid-WAIT, late response discarded
        pulse_reset("rst_pre");
        @(posedge clk); #1;
        man_ready = 1'b1;
        @(posedge clk); #1;
        man_ready = 1'b0;
        pulse_reset("rst_midwait");
        man_rv = 1'b1; man_data = 32'hDEAD_0001;
        @(posedge clk); #1;
        chk("late_req_valid", 32'(req_valid), 1);
        chk("late_req_addr", req_addr, RPC);
        chk("late_inst", inst, NOP);
        @(posedge clk); #1;
        chk("late_no_valid", 32'(inst_valid), 0);
        chk("late_inst2", inst, NOP);
        man_rv = 1'b0;
        push_exp(RPC, 0);
        fetch_manual(RPC, 32'h0050_0093);
        chk("restart_cnt", 32'(retired_cnt), 0);

        @(posedge clk); #1;
        chk("sb_drained", 32'(sb.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
